program_counter: RTL and testbench



---
 rtl/program_counter.sv | 94 +++++++++
 tb/tb_program_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Instruction sequencer: issues ROM words one at a time to the systolic-array
// core with a one-cycle start strobe, advancing only once the core reports
// completion (rising edge of flag) or the host forces it.
module program_counter #(
  parameter int unsigned PC_DEPTH  = 1024,
  parameter int unsigned INST_BITS = 128,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flag,
  input  logic                 force_inst,
  output logic [INST_BITS-1:0] instruction,
  output logic                 init_inst_pulse
);

  // Keep the counter at least one bit wide so a single-word ROM still elaborates.
  localparam int unsigned PcW = (PC_DEPTH > 1) ? $clog2(PC_DEPTH) : 1;
  localparam logic [PcW-1:0] PcLast = PcW'(PC_DEPTH - 1);

  typedef enum logic [1:0] {StFetch, StWait, StDone} state_e;

  // Program image is fixed at elaboration; reset never touches it.
  logic [INST_BITS-1:0] rom_mem [PC_DEPTH] = '{default: '0};

  state_e               state_q, state_d;
  logic [PcW-1:0]       pc_q, pc_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic                 pulse_q, pulse_d;
  logic                 flag_q;
  logic [INST_BITS-1:0] rom_word;
  logic                 complete;

  assign rom_word = rom_mem[pc_q];
  // A held-high flag counts once; force_inst coinciding with a rise is one event.
  assign complete = (flag & ~flag_q) | force_inst;

  // Next-state: fetch/issue, wait for completion, halt on a zero word or end of ROM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (rom_word != '0) begin
          inst_d  = rom_word;
          pulse_d = 1'b1;
          state_d = StWait;
        end else begin
          inst_d  = '0;
          state_d = StDone;
        end
      end
      StWait: begin
        if (complete) begin
          if (pc_q == PcLast) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      inst_q  <= '0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pulse_q <= pulse_d;
      flag_q  <= flag;
    end
  end

  assign instruction     = inst_q;
  assign init_inst_pulse = pulse_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  localparam int Fetching = 0;
  localparam int Waiting  = 1;
  localparam int Halted   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        flg [2];
  logic        frc [2];
  logic [31:0] inst0, inst1;
  logic        pul0, pul1;

  int unsigned depth [2] = '{16, 4};
  logic [31:0] rom [2][16];

  // Reference model state
  int          m_pc    [2];
  int          m_mode  [2];
  logic [31:0] m_inst  [2];
  logic        m_pulse [2];
  logic        m_fprev [2];

  int checks = 0;
  int errors = 0;
  int pulses1 = 0;

  localparam logic [31:0] WordA = 32'hA5A5_0001;
  localparam logic [31:0] WordB = 32'h5A5A_0002;

  program_counter #(.PC_DEPTH(16), .INST_BITS(32), .INIT_FILE("")) dut (
    .clk(clk), .reset(rst[0]), .flag(flg[0]), .force_inst(frc[0]),
    .instruction(inst0), .init_inst_pulse(pul0)
  );

  program_counter #(.PC_DEPTH(4), .INST_BITS(32), .INIT_FILE("")) dut4 (
    .clk(clk), .reset(rst[1]), .flag(flg[1]), .force_inst(frc[1]),
    .instruction(inst1), .init_inst_pulse(pul1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input int u);
    for (int i = 0; i < int'(depth[u]); i++) begin
      if (u == 0) dut.rom_mem[i] = rom[0][i];
      else        dut4.rom_mem[i] = rom[1][i];
    end
  endtask

  // One clock edge of the sequencer, described by its rules rather than its registers.
  task automatic model_step(input int u);
    logic done_ev;
    done_ev = (flg[u] && !m_fprev[u]) || frc[u];
    if (rst[u]) begin
      m_pc[u] = 0; m_mode[u] = Fetching; m_inst[u] = '0; m_pulse[u] = 1'b0; m_fprev[u] = 1'b0;
    end else begin
      m_pulse[u] = 1'b0;
      if (m_mode[u] == Fetching) begin
        if (rom[u][m_pc[u]] != 0) begin
          m_inst[u] = rom[u][m_pc[u]]; m_pulse[u] = 1'b1; m_mode[u] = Waiting;
        end else begin
          m_inst[u] = '0; m_mode[u] = Halted;
        end
      end else if (m_mode[u] == Waiting && done_ev) begin
        if (m_pc[u] == int'(depth[u]) - 1) m_mode[u] = Halted;
        else begin
          m_pc[u]++; m_mode[u] = Fetching;
        end
      end
      m_fprev[u] = flg[u];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (pul1 === 1'b1) pulses1++;
    check("inst0", inst0, m_inst[0]);
    check("pulse0", 32'(pul0), 32'(m_pulse[0]));
    check("pc0", 32'(dut.pc_q), 32'(m_pc[0]));
    check("inst1", inst1, m_inst[1]);
    check("pulse1", 32'(pul1), 32'(m_pulse[1]));
    check("pc1", 32'(dut4.pc_q), 32'(m_pc[1]));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; flg[u] = 1'b0; frc[u] = 1'b0;
      m_pc[u] = 0; m_mode[u] = Fetching; m_inst[u] = '0; m_pulse[u] = 1'b0; m_fprev[u] = 1'b0;
      for (int i = 0; i < 16; i++) rom[u][i] = $urandom() | 32'h1;
    end
    rom[0][0] = WordA;
    rom[0][1] = WordB;
    rom[0][2] = '0;
    load_rom(0);
    load_rom(1);
    tick();
    tick();
    check("reset_inst", inst0, 32'h0);
    check("reset_pulse", 32'(pul0), 32'h0);

    // Release: first word issued on the first non-reset edge.
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();
    check("first_issue", inst0, WordA);
    check("first_pulse", 32'(pul0), 32'h1);
    tick();
    check("pulse_one_cycle", 32'(pul0), 32'h0);
    repeat (3) tick();

    // Flag rise advances to B two cycles later; next rise hits HALT.
    flg[0] = 1'b1; tick();
    tick();
    check("second_issue", inst0, WordB);
    check("second_pulse", 32'(pul0), 32'h1);
    check("second_pc", 32'(dut.pc_q), 32'h1);
    flg[0] = 1'b0; tick();
    flg[0] = 1'b1; tick();
    tick();
    check("halt_inst", inst0, 32'h0);
    check("halt_pulse", 32'(pul0), 32'h0);
    for (int k = 0; k < 6; k++) begin
      flg[0] = 1'(k); frc[0] = 1'(k >> 1);
      tick();
    end
    check("done_pc", 32'(dut.pc_q), 32'h2);
    flg[0] = 1'b0; frc[0] = 1'b0;

    // New program; held-high flag and force_inst behaviour.
    rst[0] = 1'b1; tick();
    for (int i = 0; i < 16; i++) rom[0][i] = $urandom() | 32'h1;
    load_rom(0);
    tick();
    rst[0] = 1'b0; tick();
    tick();
    flg[0] = 1'b1; tick();
    tick();
    repeat (4) tick();
    check("held_flag_pc", 32'(dut.pc_q), 32'h1);
    flg[0] = 1'b0; tick();
    flg[0] = 1'b1; tick();
    tick();
    frc[0] = 1'b1; tick();
    frc[0] = 1'b0; tick();
    check("force_pc", 32'(dut.pc_q), 32'h3);
    check("force_pulse", 32'(pul0), 32'h1);
    flg[0] = 1'b0; tick();
    flg[0] = 1'b1; frc[0] = 1'b1; tick();
    frc[0] = 1'b0; tick();
    tick();
    check("force_and_rise_pc", 32'(dut.pc_q), 32'h4);

    // Reset while waiting at pc=2.
    rst[0] = 1'b1; tick();
    rst[0] = 1'b0; flg[0] = 1'b0; tick();
    for (int k = 0; k < 2; k++) begin
      frc[0] = 1'b1; tick();
      frc[0] = 1'b0; tick();
    end
    tick();
    check("pre_reset_pc", 32'(dut.pc_q), 32'h2);
    rst[0] = 1'b1; tick();
    check("midreset_inst", inst0, 32'h0);
    check("midreset_pulse", 32'(pul0), 32'h0);
    check("midreset_pc", 32'(dut.pc_q), 32'h0);
    rst[0] = 1'b0; tick();
    check("reissue_inst", inst0, rom[0][0]);
    check("reissue_pulse", 32'(pul0), 32'h1);

    // Four-word ROM: four completions, then stop at pc=3 without wrapping.
    for (int k = 0; k < 4; k++) begin
      flg[1] = 1'b1; tick();
      flg[1] = 1'b0; tick();
    end
    for (int k = 0; k < 4; k++) begin
      frc[1] = 1'b1; flg[1] = 1'(k); tick();
    end
    frc[1] = 1'b0; flg[1] = 1'b0;
    check("depth4_pulses", 32'(pulses1), 32'h4);
    check("depth4_pc", 32'(dut4.pc_q), 32'h3);
    check("depth4_inst", inst1, rom[1][3]);

    // Randomised traffic on both instances, with occasional resets and sparse HALT words.
    for (int u = 0; u < 2; u++) rst[u] = 1'b1;
    tick();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++)
        rom[u][i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom() | 32'h1);
      load_rom(u);
    end
    tick();
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < 2; u++) begin
        rst[u] = ($urandom_range(0, 49) == 0);
        flg[u] = 1'($urandom_range(0, 1));
        frc[u] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
